vga_rx_monitor: RTL and testbench
=================================

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT=16, H_SYNC=96, H_BACK=48, giving a line total of 800 clocks.
REQ-003 SHALL have parameters V_DISPLAY=480, V_FRONT=10, V_SYNC=2, V_BACK=33, giving a frame total of 525 lines.
REQ-004 SHALL have `clk`, input, 1 bit: the pixel clock, the single clock for all logic.
REQ-005 SHALL have `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have `vga_in`, input, 8 bits: TinyVGA PMOD bus {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}, synchronous to clk; hsync and vsync are active-low.
REQ-007 SHALL have `rx_x`, output, 10 bits: reconstructed horizontal position of the output pixel.
REQ-008 SHALL have `rx_y`, output, 10 bits: reconstructed vertical position of the output pixel.
REQ-009 SHALL have `rx_r`, `rx_g`, `rx_b`, outputs, 2 bits each: decoded colour of the output pixel.
REQ-010 SHALL have `rx_active`, output, 1 bit: output pixel is inside the visible area while locked.
REQ-011 SHALL have `locked`, output, 1 bit: timing has been verified and is currently consistent.
REQ-012 SHALL have `frame_start`, output, 1 bit: one-cycle pulse marking the output pixel (0,0) while locked.
REQ-013 SHALL have `sync_err`, output, 1 bit: one-cycle pulse on any timing violation.
REQ-014 SHALL have `err_count`, output, 8 bits: count of sync_err pulses, saturating.
REQ-015 SHALL have `lit_count`, output, 19 bits: non-black visible pixels in the last complete locked frame.

Function
REQ-016 SHALL register vga_in once (stage 1); all edge detection SHALL use stage 1 and its one-cycle-delayed copy; all outputs SHALL be registered (stage 2), giving 2-clock latency from bus pixel to output pixel.
REQ-017 SHALL keep hcnt (0..799) and vcnt (0..524); hcnt wraps 799->0; vcnt increments only on that wrap and wraps 524->0.
REQ-018 SHALL treat hsync falling at stage 1 as hpos=656 (H_DISPLAY+H_FRONT) and hsync rising as hpos=752.
REQ-019 SHALL treat a vsync falling edge as vpos=490 coinciding with hpos=0, and a vsync rising edge as vpos=492.
REQ-020 SHALL use FSM states SEEK_H, SEEK_V, VERIFY, LOCKED.
REQ-021 SEEK_H: on hsync fall, load hcnt=656 and go to SEEK_V.
REQ-022 SEEK_V: on vsync fall, load vcnt=490 and go to VERIFY.
REQ-023 VERIFY: on the next vsync fall with no error since entry, go to LOCKED.
REQ-024 In SEEK_V, VERIFY and LOCKED, an error SHALL be flagged when any of the following occurs:
- hsync falls while the free-running hcnt is not 656;
- hsync rises while hcnt is not 752;
- vsync falls while (vcnt, hcnt) is not (490, 0);
- vsync rises while (vcnt, hcnt) is not (492, 0);
- no hsync fall is seen within 1024 clocks (loss of signal).
REQ-025 On error: pulse sync_err for 1 clock, increment err_count (held at 255), go to SEEK_H, and clear locked on the next clock.
REQ-026 Only one error SHALL be counted per clock even if several checks fail together.
REQ-027 In SEEK_H, no errors SHALL be flagged except the loss-of-signal timeout, which counts once per 1024-clock window.
REQ-028 locked SHALL be 1 exactly when the state is LOCKED.
REQ-029 rx_active SHALL be 1 when locked, hcnt<640 and vcnt<480, aligned to the output pixel.
REQ-030 rx_r, rx_g, rx_b SHALL carry the bus colour when rx_active is 1, and 0 otherwise.
REQ-031 rx_x and rx_y SHALL be valid only while locked; otherwise they SHALL be 0.
REQ-032 frame_start SHALL be asserted when locked and the output pixel is (0,0).
REQ-033 SHALL accumulate the count of visible non-black pixels (any colour bit set) while locked; at each vsync fall in LOCKED, latch the accumulator into lit_count and clear it.
REQ-034 On entry to SEEK_H, the accumulator SHALL be cleared and lit_count SHALL hold its last value.

Reset
REQ-035 When rst_n is low, all outputs SHALL be 0: rx_x, rx_y, colours, rx_active, locked, frame_start, sync_err, err_count and lit_count.
REQ-036 When rst_n is low, the FSM SHALL be in SEEK_H, all counters and pipeline registers SHALL be 0, and registered syncs SHALL be 1 (inactive).
REQ-037 Reset asserted mid-frame SHALL take effect immediately; after release, the block SHALL re-acquire from SEEK_H without counting an error.

Verification
REQ-038 Clean 640x480 stream from reset -> locked rises at the second vsync fall; sync_err is never pulsed; frame_start arrives exactly 420000 clocks apart.
REQ-039 Frame lit with a 100x100 white square -> lit_count = 10000 after the first full locked frame.
REQ-040 While locked, one hsync fall delayed by 1 clock -> a single sync_err pulse, err_count 0->1, locked=0, then re-lock after two further vsync falls.
REQ-041 Syncs held high for 2000 clocks while locked -> one error at the 1024-clock timeout, then one more per further 1024 clocks in SEEK_H; rx_active stays 0.
REQ-042 Pixel (5,7) driven as R=3, G=0, B=2 -> rx_x=5, rx_y=7, rx_r=3, rx_g=0, rx_b=2 exactly 2 clocks later.
REQ-043 300 injected errors -> err_count saturates at 255; rst_n pulsed low mid-line -> all outputs read 0 immediately.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - recovers pixel position and timing lock from a TinyVGA PMOD bus
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   vga_in[7:0]         {hsync, B0, G0, R0, vsync, B1, G1, R1}, syncs active-low
//   rx_x, rx_y          position of the output pixel (0 unless locked)
//   rx_r, rx_g, rx_b    colour of the output pixel (0 outside the visible area)
//   rx_active           output pixel is visible and timing is locked
//   locked              timing verified and still consistent
//   frame_start         one-cycle pulse on output pixel (0,0) while locked
//   sync_err            one-cycle pulse on any timing violation
//   err_count           saturating count of sync_err pulses
//   lit_count           non-black visible pixels of the last complete locked frame

module vga_rx_monitor #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [1:0]  rx_r,
    output logic [1:0]  rx_g,
    output logic [1:0]  rx_b,
    output logic        rx_active,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic [18:0] lit_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS   = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FALL = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_RISE = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_FALL = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_RISE = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] LOS_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEEK_H = 2'd0,
        SEEK_V = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [7:0]  s1;
    logic        d_hs, d_vs;
    logic [9:0]  hcnt, vcnt, hcnt_next, vcnt_next;
    logic [9:0]  los_cnt;
    logic [18:0] acc;

    logic hs1, vs1;
    logic hs_fall, hs_rise, vs_fall, vs_rise;
    logic los_err, h_err, v_err, err;
    logic pix_on, lit_px;

    assign hs1     = s1[7];
    assign vs1     = s1[3];
    assign hs_fall = d_hs & ~hs1;
    assign hs_rise = ~d_hs & hs1;
    assign vs_fall = d_vs & ~vs1;
    assign vs_rise = ~d_vs & vs1;

    // hcnt/vcnt always describe the pixel currently held in stage 1.
    always_comb begin
        state_next = state;
        hcnt_next  = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
        vcnt_next  = vcnt;
        if (hcnt == H_LAST) begin
            vcnt_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end

        los_err = (los_cnt == LOS_MAX) && !hs_fall;
        h_err   = 1'b0;
        v_err   = 1'b0;

        if (state != SEEK_H) begin
            h_err = (hs_fall && hcnt != HS_FALL) || (hs_rise && hcnt != HS_RISE);
        end
        if (state == SEEK_V) begin
            // vcnt is not yet established here, so only the line phase of the
            // vsync fall can be judged and a vsync rise carries no information.
            v_err = vs_fall && hcnt != 10'd0;
        end else if (state != SEEK_H) begin
            v_err = (vs_fall && (vcnt != VS_FALL || hcnt != 10'd0)) ||
                    (vs_rise && (vcnt != VS_RISE || hcnt != 10'd0));
        end
        err = los_err || h_err || v_err;

        if (state == SEEK_H && hs_fall) begin
            hcnt_next = HS_FALL + 10'd1;
        end
        if (state == SEEK_V && vs_fall) begin
            vcnt_next = VS_FALL;
        end

        if (err) begin
            state_next = SEEK_H;
        end else begin
            case (state)
                SEEK_H:  if (hs_fall) state_next = SEEK_V;
                SEEK_V:  if (vs_fall) state_next = VERIFY;
                VERIFY:  if (vs_fall) state_next = LOCKED;
                default: state_next = LOCKED;
            endcase
        end

        pix_on = (state == LOCKED) && (hcnt < H_VIS) && (vcnt < V_VIS);
        lit_px = pix_on && ((s1[6:4] != 3'd0) || (s1[2:0] != 3'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEEK_H;
            s1          <= 8'h88;
            d_hs        <= 1'b1;
            d_vs        <= 1'b1;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            los_cnt     <= 10'd0;
            acc         <= 19'd0;
            rx_x        <= 10'd0;
            rx_y        <= 10'd0;
            rx_r        <= 2'd0;
            rx_g        <= 2'd0;
            rx_b        <= 2'd0;
            rx_active   <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 8'd0;
            lit_count   <= 19'd0;
        end else begin
            state <= state_next;
            s1    <= vga_in;
            d_hs  <= hs1;
            d_vs  <= vs1;
            hcnt  <= hcnt_next;
            vcnt  <= vcnt_next;

            // Restarting on a timeout gives one loss-of-signal error per window.
            if (hs_fall || los_err) begin
                los_cnt <= 10'd0;
            end else begin
                los_cnt <= los_cnt + 10'd1;
            end

            if (state_next == SEEK_H) begin
                acc <= 19'd0;
            end else if (state == LOCKED && vs_fall) begin
                lit_count <= acc;
                acc       <= 19'd0;
            end else if (lit_px) begin
                acc <= acc + 19'd1;
            end

            rx_x        <= (state == LOCKED) ? hcnt : 10'd0;
            rx_y        <= (state == LOCKED) ? vcnt : 10'd0;
            rx_r        <= pix_on ? {s1[0], s1[4]} : 2'd0;
            rx_g        <= pix_on ? {s1[1], s1[5]} : 2'd0;
            rx_b        <= pix_on ? {s1[2], s1[6]} : 2'd0;
            rx_active   <= pix_on;
            locked      <= (state_next == LOCKED);
            frame_start <= (state == LOCKED) && (hcnt == 10'd0) && (vcnt == 10'd0);
            sync_err    <= err;
            if (err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed self-checking bench for vga_rx_monitor (reduced timing)

module tb_vga_rx_monitor;

    localparam int HD = 16, HF = 4, HSW = 8, HB = 4;
    localparam int VD = 12, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int H_FALL = HD + HF;
    localparam int H_RISE = HD + HF + HSW;
    localparam int V_FALL = VD + VF;
    localparam int V_RISE = VD + VF + VSW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_in = 8'h88;
    logic [9:0]  rx_x, rx_y;
    logic [1:0]  rx_r, rx_g, rx_b;
    logic        rx_active, locked, frame_start, sync_err;
    logic [7:0]  err_count;
    logic [18:0] lit_count;

    vga_rx_monitor #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
        .rx_x(rx_x), .rx_y(rx_y), .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
        .rx_active(rx_active), .locked(locked), .frame_start(frame_start),
        .sync_err(sync_err), .err_count(err_count), .lit_count(lit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0, err_pulses = 0, err_cyc_last = 0, err_cyc_prev = 0;
    int fs_cnt = 0, fs_last = 0, fs_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (sync_err === 1'b1) begin
            err_pulses++;
            err_cyc_prev = err_cyc_last;
            err_cyc_last = cyc;
        end
        if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_prev = fs_last;
            fs_last = cyc;
        end
    end

    int bpos = 0;
    bit inj_delay = 1'b0;
    bit hold_hi = 1'b0;

    // Test picture: 4x3 white square at x 2..5, y 3..5 plus pixel (5,7) = R3 G0 B2.
    function automatic logic [7:0] bus_at(input int x, input int y);
        logic       hs, vs;
        logic [1:0] r, g, b;
        hs = !(x >= (inj_delay ? H_FALL + 1 : H_FALL) && x < H_RISE);
        vs = !(y >= V_FALL && y < V_RISE);
        r = 2'd0; g = 2'd0; b = 2'd0;
        if (x >= 2 && x < 6 && y >= 3 && y < 6) begin
            r = 2'd3; g = 2'd3; b = 2'd3;
        end
        if (x == 5 && y == 7) begin
            r = 2'd3; b = 2'd2;
        end
        if (hold_hi) begin
            hs = 1'b1; vs = 1'b1; r = 2'd0; g = 2'd0; b = 2'd0;
        end
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    task automatic drive_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            vga_in = bus_at(bpos % HT, bpos / HT);
            bpos = (bpos + 1) % FT;
        end
    endtask

    task automatic drive_to(input int target);
        drive_n((target - bpos + FT) % FT);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rx_x"}, rx_x, 0);
        check({pfx, "_rx_y"}, rx_y, 0);
        check({pfx, "_rx_r"}, rx_r, 0);
        check({pfx, "_rx_g"}, rx_g, 0);
        check({pfx, "_rx_b"}, rx_b, 0);
        check({pfx, "_active"}, rx_active, 0);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_frame_start"}, frame_start, 0);
        check({pfx, "_sync_err"}, sync_err, 0);
        check({pfx, "_err_count"}, err_count, 0);
        check({pfx, "_lit_count"}, lit_count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Acquisition: locked rises 2 clocks after the second vsync fall on the bus.
        bpos = 0;
        drive_to(V_FALL * HT);
        check("lock_before_v1", locked, 0);
        drive_n(FT);
        check("lock_before_v2", locked, 0);
        drive_n(2);
        check("lock_v2_plus1", locked, 0);
        drive_n(1);
        check("lock_v2_plus2", locked, 1);
        check("acq_no_err", err_pulses, 0);

        // Pixel (5,7) appears on the outputs exactly 2 clocks after the bus.
        drive_to(7 * HT + 5);
        drive_n(2);
        check("lat_prev_x", rx_x, 4);
        drive_n(1);
        check("lat_x", rx_x, 5);
        check("lat_y", rx_y, 7);
        check("lat_r", rx_r, 3);
        check("lat_g", rx_g, 0);
        check("lat_b", rx_b, 2);
        check("lat_active", rx_active, 1);

        // First complete locked frame: 12 square pixels + pixel (5,7).
        drive_to(V_FALL * HT);
        drive_n(2);
        check("lit_before_latch", lit_count, 0);
        drive_n(1);
        check("lit_latched", lit_count, 13);

        // Visible boundary at x = H_DISPLAY.
        drive_to(HD - 1);
        drive_n(3);
        check("edge_active_15", rx_active, 1);
        check("edge_x_15", rx_x, 15);
        drive_n(1);
        check("edge_active_16", rx_active, 0);
        check("edge_x_16", rx_x, 16);

        // frame_start spacing is one frame total.
        drive_to(0);
        drive_n(4);
        check("fs_count", fs_cnt, 3);
        check("fs_spacing", fs_last - fs_prev, FT);
        check("clean_err_count", err_count, 0);

        // One hsync fall delayed by a clock.
        drive_to(2 * HT);
        inj_delay = 1'b1;
        drive_n(HT);
        inj_delay = 1'b0;
        drive_n(2);
        check("dly_pulses", err_pulses, 1);
        check("dly_err_count", err_count, 1);
        check("dly_locked", locked, 0);
        drive_to(V_FALL * HT);
        drive_n(3);
        check("relock_v1", locked, 0);
        drive_to(V_FALL * HT);
        drive_n(2);
        check("relock_v2_plus1", locked, 0);
        drive_n(1);
        check("relock_v2_plus2", locked, 1);
        check("relock_pulses", err_pulses, 1);

        // Syncs held high: timeout errors 1024 clocks apart.
        drive_to(3 * HT);
        hold_hi = 1'b1;
        drive_n(2100);
        hold_hi = 1'b0;
        check("los_pulses", err_pulses, 3);
        check("los_spacing", err_cyc_last - err_cyc_prev, 1024);
        check("los_err_count", err_count, 3);
        check("los_locked", locked, 0);
        check("los_active", rx_active, 0);

        // 300 errors: each period re-acquires on the fall and fails on the early rise.
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                vga_in = (k < 2) ? 8'h08 : 8'h88;
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            vga_in = 8'h88;
        end
        check("sat_pulses", err_pulses, 303);
        check("sat_err_count", err_count, 255);
        check("sat_lit_hold", lit_count, 13);

        // Reset mid-line takes effect at once, then clean re-acquisition.
        bpos = 0;
        drive_n(10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bpos = 0;
        drive_to(V_FALL * HT);
        drive_n(FT + 3);
        check("reacq_locked", locked, 1);
        check("reacq_err_count", err_count, 0);
        check("reacq_pulses", err_pulses, 303);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
